// File: rtl/alu_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit lookahead slice per stage,
// chunk carry registered between stages, ready/valid on both sides.

module alu_cla_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK-1:0] g, p;
    logic [CHUNK:0]   c;
    logic             acc, pchain;

    assign g = a & b;
    assign p = a | b;

    // Each carry is a flat sum of g/p products plus the propagated cin, no bit ripple.
    always_comb begin
        c      = '0;
        acc    = 1'b0;
        pchain = 1'b1;
        c[0]   = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc    = 1'b0;
            pchain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc    = acc | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[i+1] = acc | (pchain & cin);
        end
    end

    assign sum   = a ^ b ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

module alu_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             Cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q, zero_q;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, r_in, r_nx;
    logic [STAGES-1:0][CHUNK-1:0] sum_w;
    logic [STAGES-1:0]            c_in, v_in, cout_w, cmsb_w;
    logic                         en, accept;

    // Whole pipe advances together; only a stalled full last stage blocks it.
    assign en       = ~vld_pipe[STAGES-1] | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k] = data_operandA;
            assign b_in[k] = data_operandB ^ {WIDTH{sub}};
            assign c_in[k] = sub | Cin;
            assign r_in[k] = '0;
            assign v_in[k] = accept;
        end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign r_in[k] = r_q[k-1];
            assign v_in[k] = vld_pipe[k-1];
        end

        alu_cla_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .cin   (c_in[k]),
            .sum   (sum_w[k]),
            .cout  (cout_w[k]),
            .c_msb (cmsb_w[k])
        );

        // Chunks k and above of r_in are still zero, so OR-ing in the new slice is exact.
        assign r_nx[k] = r_in[k] | (WIDTH'(sum_w[k]) << (k*CHUNK));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (en) begin
            vld_pipe <= v_in;
            a_q      <= a_in;
            b_q      <= b_in;
            r_q      <= r_nx;
            c_q      <= cout_w;
            ovf_q    <= cout_w[STAGES-1] ^ cmsb_w[STAGES-1];
            zero_q   <= ~|r_nx[STAGES-1];
        end
    end

    assign out_valid   = vld_pipe[STAGES-1];
    assign data_result = r_q[STAGES-1];
    assign Cout        = c_q[STAGES-1];
    assign overflow    = ovf_q;
    assign zero        = zero_q;

    // Last-stage operand copies and interior MSB carries have no consumer.
    logic unused_ok;
    assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], cmsb_w};
endmodule

// File: tb/tb_alu_cla_pipe.sv
// Directed bench for alu_cla_pipe (WIDTH=32, STAGES=4): flags, latency, streaming,
// backpressure and asynchronous reset.

module tb_alu_cla_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] data_operandA, data_operandB;
    logic             Cin, sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] data_result;
    logic             Cout, overflow, zero;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_cla_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .Cin           (Cin),
        .sub           (sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .Cout          (Cout),
        .overflow      (overflow),
        .zero          (zero)
    );

    // Reference: {cout, ovf, zero, result} from plain wide arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, b, input logic c, s);
        logic [31:0] bb;
        logic [32:0] t;
        logic        ov;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? 1'b1 : c)};
        ov = (a[31] == bb[31]) && (t[31] != a[31]);
        return {t[32], ov, (t[31:0] == 32'd0), t[31:0]};
    endfunction

    task automatic drive(input logic [31:0] a, b, input logic c, s);
        data_operandA = a;
        data_operandB = b;
        Cin           = c;
        sub           = s;
    endtask

    task automatic drain();
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 1) @(posedge clock);
    endtask

    // Issue one op into an otherwise idle pipe; report the result and edges until out_valid.
    task automatic run_op(input logic [31:0] a, b, input logic c, s,
                          output logic [34:0] obs, output int lat);
        @(negedge clock);
        drive(a, b, c, s);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clock);
            #1;
            lat++;
        end
        obs = {Cout, overflow, zero, data_result};
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({Cout, overflow, zero, data_result} !== 35'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", {Cout, overflow, zero, data_result});
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] va[5], vb[5];
        logic        vc[5];
        logic [34:0] ve[5];
        logic [34:0] obs;
        int          lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0; ve[0] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
        va[1] = 32'h00FF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0; ve[1] = {1'b0, 1'b0, 1'b0, 32'h0100_0000};
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1; ve[2] = {1'b0, 1'b1, 1'b0, 32'h8000_0000};
        va[3] = 32'h0000_0003; vb[3] = 32'h0000_0004; vc[3] = 1'b1; ve[3] = {1'b0, 1'b0, 1'b0, 32'h0000_0008};
        va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000; vc[4] = 1'b0; ve[4] = {1'b1, 1'b1, 1'b1, 32'h0000_0000};
        drain();
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, obs, lat);
            checks++;
            if (obs !== ve[i]) begin
                errors++;
                $display("FAIL add[%0d] {cout,ovf,zero,result}: got %h expected %h", i, obs, ve[i]);
            end
            checks++;
            if (lat != STAGES) begin
                errors++;
                $display("FAIL add_latency[%0d]: got %0d expected %0d", i, lat, STAGES);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] va[4], vb[4];
        logic        vc[4];
        logic [34:0] ve[4];
        logic [34:0] obs;
        int          lat;
        va[0] = 32'h8000_0000; vb[0] = 32'h0000_0001; vc[0] = 1'b0; ve[0] = {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF};
        va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001; vc[1] = 1'b0; ve[1] = {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF};
        va[2] = 32'h0000_0005; vb[2] = 32'h0000_0003; vc[2] = 1'b1; ve[2] = {1'b1, 1'b0, 1'b0, 32'h0000_0002};
        va[3] = 32'h1234_5678; vb[3] = 32'h1234_5678; vc[3] = 1'b0; ve[3] = {1'b1, 1'b0, 1'b1, 32'h0000_0000};
        drain();
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b1, obs, lat);
            checks++;
            if (obs !== ve[i]) begin
                errors++;
                $display("FAIL sub[%0d] {cout,ovf,zero,result}: got %h expected %h", i, obs, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] exp_q[$];
        logic [34:0] obs, e;
        logic [31:0] a, b;
        logic        c, s;
        int          n, got;
        n = 0;
        got = 0;
        a = '0; b = '0; c = 1'b0; s = 1'b0;
        drain();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clock);
            out_ready = 1'b1;
            if (n < 8) begin
                a = 32'h0F0F_00FF + n * 32'h2222_2223;
                b = 32'hFFFF_0101 - n * 32'h1357_0000;
                c = n[1];
                s = n[0];
                drive(a, b, c, s);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                obs = {Cout, overflow, zero, data_result};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got %h expected no result", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL b2b[%0d]: got %h expected %h", got, obs, e);
                    end
                end
                checks++;
                if (cyc != STAGES + got) begin
                    errors++;
                    $display("FAIL b2b_timing[%0d]: seen at cycle %0d expected %0d", got, cyc, STAGES + got);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c, s));
                n++;
            end
            @(posedge clock);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 8", got);
        end
    endtask

    task automatic test_stall();
        logic [34:0] exp_q[$];
        logic [34:0] obs, e, hold;
        logic [31:0] a, b;
        logic        c, s, rel;
        int          n, got, held;
        n = 0; got = 0; held = 0; rel = 1'b0;
        a = '0; b = '0; c = 1'b0; s = 1'b0; hold = '0;
        drain();
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            out_ready = rel;
            if (n < 6) begin
                a = 32'h8000_0000 + n * 32'h0101_0101;
                b = 32'h7FFF_00FF - n * 32'h0011_2233;
                c = ~n[0];
                s = n[1];
                drive(a, b, c, s);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            obs = {Cout, overflow, zero, data_result};
            if (!rel && out_valid) begin
                if (held == 0) begin
                    hold = obs;
                end else begin
                    checks++;
                    if (obs !== hold) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: got %h expected %h", held, obs, hold);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready[%0d]: got %b expected 0", held, in_ready);
                end
                held++;
                if (held == 4) rel = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: got %h expected no result", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL stall_order[%0d]: got %h expected %h", got, obs, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c, s));
                n++;
            end
            @(posedge clock);
        end
        in_valid = 1'b0;
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalled cycles expected 4", held);
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL stall_count: got %0d results expected 6", got);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] va[3], vb[3];
        logic [34:0] obs;
        int          lat, stale;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0002;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001;
        va[2] = 32'h0000_1234; vb[2] = 32'h0000_4321;
        drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            out_ready = 1'b0;
            drive(va[i], vb[i], 1'b0, 1'b0);
            in_valid = 1'b1;
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        checks++;
        if (out_valid !== 1'b1 || data_result !== 32'h0000_0001 || Cout !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: got valid=%b result=%h cout=%b expected 1/00000001/1",
                     out_valid, data_result, Cout);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({Cout, overflow, zero, data_result} !== 35'h0) begin
            errors++;
            $display("FAIL midflight_fields: got %h expected 0", {Cout, overflow, zero, data_result});
        end
        @(negedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_in_ready: got %b expected 1", in_ready);
        end
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d stale results expected 0", stale);
        end
        run_op(32'd2, 32'd3, 1'b0, 1'b0, obs, lat);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h0000_0005}) begin
            errors++;
            $display("FAIL midflight_2plus3: got %h expected %h", obs, {1'b0, 1'b0, 1'b0, 32'h0000_0005});
        end
        checks++;
        if (lat != STAGES) begin
            errors++;
            $display("FAIL midflight_latency: got %0d expected %0d", lat, STAGES);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
